// File: rtl/noc_pkg.sv
// Shared NoC definitions: port counts, select width and arbiter state encoding.
package noc_pkg;

  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;
  localparam int FLIT_W = 11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  // Convert a select value (0..2) into a one-hot port vector; 3 maps to no port.
  function automatic logic [NUM_IN-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_IN-1:0] oh;
    case (sel)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/merge_arbiter_if.sv
// Handshake bundle between the input ports, the merge control channel and the
// downstream credit return. The master side is the arbiter itself.
interface merge_arbiter_if import noc_pkg::*; ();

  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] req_ack;
  logic              ctrl_valid;
  logic              ctrl_ready;
  logic [SEL_W-1:0]  ctrl_data;
  logic              credit_ret;
  logic              credit_err;

  modport master (
    input  req,
    input  ctrl_ready,
    input  credit_ret,
    output req_ack,
    output ctrl_valid,
    output ctrl_data,
    output credit_err
  );

  modport slave (
    output req,
    output ctrl_ready,
    output credit_ret,
    input  req_ack,
    input  ctrl_valid,
    input  ctrl_data,
    input  credit_err
  );

endinterface

// File: rtl/rr_pick3.sv
// Three-way round-robin pick: the search starts at the port after the last
// grant and wraps modulo 3, so the last granted port is checked last.
module rr_pick3 import noc_pkg::*; (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [SEL_W-1:0]  sel,
  output logic              any
);

  // Priority search rotated by the previous grant.
  always_comb begin
    sel = 2'd0;
    any = |req;
    case (last)
      2'd0: begin
        if (req[1])      sel = 2'd1;
        else if (req[2]) sel = 2'd2;
        else if (req[0]) sel = 2'd0;
        else             sel = 2'd0;
      end
      2'd1: begin
        if (req[2])      sel = 2'd2;
        else if (req[0]) sel = 2'd0;
        else if (req[1]) sel = 2'd1;
        else             sel = 2'd0;
      end
      default: begin
        if (req[0])      sel = 2'd0;
        else if (req[1]) sel = 2'd1;
        else if (req[2]) sel = 2'd2;
        else             sel = 2'd0;
      end
    endcase
  end

endmodule

// File: rtl/merge_arbiter.sv
// Credit-gated round-robin arbiter that offers one select token at a time to
// a merge control channel. Every accepted token is followed by one IDLE
// bubble so a port's req has dropped before the next pick looks at it.
module merge_arbiter import noc_pkg::*; #(
  parameter int CREDITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  merge_arbiter_if.master bus
);

  localparam logic [2:0] CREDIT_MAX = 3'(CREDITS);

  arb_state_t       state_r;
  arb_state_t       state_nxt_s;
  logic [SEL_W-1:0] ctrl_data_r;
  logic [SEL_W-1:0] last_grant_r;
  logic [2:0]       credit_cnt_r;
  logic             credit_err_r;
  logic [SEL_W-1:0] pick_sel_s;
  logic             pick_any_s;
  logic             load_s;
  logic             accept_s;

  rr_pick3 u_pick (
    .req  (bus.req),
    .last (last_grant_r),
    .sel  (pick_sel_s),
    .any  (pick_any_s)
  );

  // Next-state logic: pick in IDLE when credit allows, hold the offer until accepted.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_any_s && (credit_cnt_r != 3'd0)) begin
          state_nxt_s = OFFER;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OFFER: begin
        if (bus.ctrl_ready) begin
          state_nxt_s = IDLE;
          // A reset in the handshake cycle abandons the token, so no ack.
          accept_s    = ~reset;
        end else begin
          state_nxt_s = OFFER;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the pick when an offer starts and remember the accepted port.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_data_r  <= 2'd0;
      last_grant_r <= 2'd2;
    end else begin
      if (load_s) begin
        ctrl_data_r <= pick_sel_s;
      end
      if (accept_s) begin
        last_grant_r <= ctrl_data_r;
      end
    end
  end

  // Downstream credit tracking with saturation and a sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_cnt_r <= CREDIT_MAX;
      credit_err_r <= 1'b0;
    end else begin
      case ({accept_s, bus.credit_ret})
        2'b10: begin
          credit_cnt_r <= credit_cnt_r - 3'd1;
        end
        2'b01: begin
          if (credit_cnt_r == CREDIT_MAX) begin
            credit_err_r <= 1'b1;
          end else begin
            credit_cnt_r <= credit_cnt_r + 3'd1;
          end
        end
        default: begin
          credit_cnt_r <= credit_cnt_r;
        end
      endcase
    end
  end

  assign bus.ctrl_valid = (state_r == OFFER);
  assign bus.ctrl_data  = ctrl_data_r;
  assign bus.req_ack    = accept_s ? sel_onehot(ctrl_data_r) : 3'b000;
  assign bus.credit_err = credit_err_r;

endmodule

// File: tb/tb_merge_arbiter.sv
// Self-checking bench for merge_arbiter: a directed vector table, directed
// corner-case sequences and a randomized phase, all checked against a
// behavioural model of the arbitration and credit rules.
module tb_merge_arbiter;
  import noc_pkg::*;

  localparam int C = 4;

  logic clk;
  logic reset;
  merge_arbiter_if ifc ();

  merge_arbiter #(.CREDITS(C)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit m_known = 1'b0;
  bit m_offer;
  int m_data;
  int m_last;
  int m_cnt;
  bit m_err;
  int ack_tot[3];

  typedef struct {
    bit [2:0] req;
    bit       rdy;
    bit       ret;
    bit       exp_valid;
    bit [1:0] exp_data;
    bit [2:0] exp_ack;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return 0;
  endfunction

  // One clock cycle: drive, sample at negedge and compare with the model, then advance the model.
  task automatic cyc(input bit [2:0] r, input bit rd, input bit rt, input bit rs,
                     output logic o_valid, output logic [1:0] o_data, output logic [2:0] o_ack);
    bit       acc;
    bit [2:0] exp_ack;
    ifc.req        = r;
    ifc.ctrl_ready = rd;
    ifc.credit_ret = rt;
    reset          = rs;
    @(negedge clk);
    o_valid = ifc.ctrl_valid;
    o_data  = ifc.ctrl_data;
    o_ack   = ifc.req_ack;
    acc     = m_offer && rd && !rs;
    exp_ack = acc ? (3'b001 << m_data) : 3'b000;
    if (m_known) begin
      chk("ctrl_valid", 32'(ifc.ctrl_valid), 32'(m_offer));
      chk("ctrl_data",  32'(ifc.ctrl_data),  32'(m_data));
      chk("req_ack",    32'(ifc.req_ack),    32'(exp_ack));
      chk("credit_err", 32'(ifc.credit_err), 32'(m_err));
    end
    for (int p = 0; p < 3; p++) begin
      if (ifc.req_ack[p] === 1'b1) ack_tot[p]++;
    end
    @(posedge clk);
    if (rs) begin
      m_offer = 1'b0; m_data = 0; m_last = 2; m_cnt = C; m_err = 1'b0; m_known = 1'b1;
    end else if (m_known) begin
      if (acc) begin
        m_offer = 1'b0;
        m_last  = m_data;
      end else if (!m_offer && r != 3'b000 && m_cnt > 0) begin
        m_data  = pick(r, m_last);
        m_offer = 1'b1;
      end
      if (acc && !rt) m_cnt--;
      else if (rt && !acc) begin
        if (m_cnt == C) m_err = 1'b1;
        else m_cnt++;
      end
    end
    #1;
  endtask

  task automatic run(input int n, input bit [2:0] r, input bit rd);
    logic v; logic [1:0] d; logic [2:0] a;
    for (int i = 0; i < n; i++) cyc(r, rd, 1'b0, 1'b0, v, d, a);
  endtask

  task automatic do_reset();
    logic v; logic [1:0] d; logic [2:0] a;
    cyc(3'b000, 1'b0, 1'b0, 1'b1, v, d, a);
    cyc(3'b000, 1'b0, 1'b0, 1'b1, v, d, a);
    for (int p = 0; p < 3; p++) ack_tot[p] = 0;
  endtask

  initial begin
    logic v; logic [1:0] d; logic [2:0] a;
    ifc.req = 3'b000; ifc.ctrl_ready = 1'b0; ifc.credit_ret = 1'b0; reset = 1'b1;

    // Rotation 0,1,2,0 then credit exhaustion and one returned credit
    tv[0]  = '{3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000};
    tv[1]  = '{3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 3'b001};
    tv[2]  = '{3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000};
    tv[3]  = '{3'b111, 1'b1, 1'b0, 1'b1, 2'd1, 3'b010};
    tv[4]  = '{3'b111, 1'b1, 1'b0, 1'b0, 2'd1, 3'b000};
    tv[5]  = '{3'b111, 1'b1, 1'b0, 1'b1, 2'd2, 3'b100};
    tv[6]  = '{3'b111, 1'b1, 1'b0, 1'b0, 2'd2, 3'b000};
    tv[7]  = '{3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 3'b001};
    tv[8]  = '{3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000};
    tv[9]  = '{3'b111, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000};
    tv[10] = '{3'b111, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000};
    tv[11] = '{3'b111, 1'b1, 1'b0, 1'b1, 2'd1, 3'b010};

    do_reset();
    chk("reset_valid", 32'(ifc.ctrl_valid), 32'd0);
    chk("reset_data",  32'(ifc.ctrl_data),  32'd0);
    chk("reset_ack",   32'(ifc.req_ack),    32'd0);
    chk("reset_err",   32'(ifc.credit_err), 32'd0);

    for (int i = 0; i < 12; i++) begin
      cyc(tv[i].req, tv[i].rdy, tv[i].ret, 1'b0, v, d, a);
      chk($sformatf("tv%0d_valid", i), 32'(v), 32'(tv[i].exp_valid));
      chk($sformatf("tv%0d_data", i),  32'(d), 32'(tv[i].exp_data));
      chk($sformatf("tv%0d_ack", i),   32'(a), 32'(tv[i].exp_ack));
    end

    // Exactly CREDITS tokens without credit return, then one more per returned credit
    do_reset();
    run(24, 3'b001, 1'b1);
    chk("credit_exhaust_tokens", ack_tot[0], C);
    cyc(3'b001, 1'b1, 1'b0, 1'b0, v, d, a);
    chk("credit_exhaust_idle", 32'(v), 32'd0);
    cyc(3'b001, 1'b1, 1'b1, 1'b0, v, d, a);
    run(10, 3'b001, 1'b1);
    chk("credit_one_more", ack_tot[0], C + 1);

    // Offer held stable while ready is low and req changes
    do_reset();
    cyc(3'b010, 1'b0, 1'b0, 1'b0, v, d, a);
    for (int i = 0; i < 5; i++) begin
      cyc(3'b100, 1'b0, 1'b0, 1'b0, v, d, a);
      chk("hold_valid", 32'(v), 32'd1);
      chk("hold_data",  32'(d), 32'd1);
      chk("hold_ack",   32'(a), 32'd0);
    end
    cyc(3'b100, 1'b1, 1'b0, 1'b0, v, d, a);
    chk("hold_release_ack", 32'(a), 32'b010);

    // Accept and credit return together at count 2
    do_reset();
    run(4, 3'b001, 1'b1);
    cyc(3'b001, 1'b1, 1'b0, 1'b0, v, d, a);
    cyc(3'b001, 1'b1, 1'b1, 1'b0, v, d, a);
    chk("acc_ret_ack", 32'(a), 32'b001);
    for (int p = 0; p < 3; p++) ack_tot[p] = 0;
    run(20, 3'b001, 1'b1);
    chk("acc_ret_tokens", ack_tot[0], 2);
    chk("acc_ret_no_err", 32'(ifc.credit_err), 32'd0);

    // Credit overflow at full count: saturates and sets the sticky flag
    do_reset();
    cyc(3'b000, 1'b0, 1'b1, 1'b0, v, d, a);
    run(5, 3'b000, 1'b0);
    chk("overflow_err", 32'(ifc.credit_err), 32'd1);
    for (int p = 0; p < 3; p++) ack_tot[p] = 0;
    run(20, 3'b001, 1'b1);
    chk("overflow_saturated_tokens", ack_tot[0], C);
    chk("overflow_err_sticky", 32'(ifc.credit_err), 32'd1);
    do_reset();
    cyc(3'b000, 1'b0, 1'b0, 1'b0, v, d, a);
    chk("overflow_err_cleared", 32'(ifc.credit_err), 32'd0);

    // Reset during OFFER abandons the token; first grant afterwards is port 0
    do_reset();
    cyc(3'b010, 1'b0, 1'b0, 1'b0, v, d, a);
    cyc(3'b010, 1'b1, 1'b0, 1'b1, v, d, a);
    chk("rst_offer_ack", 32'(a), 32'd0);
    cyc(3'b111, 1'b1, 1'b0, 1'b0, v, d, a);
    chk("rst_offer_valid_after", 32'(v), 32'd0);
    chk("rst_offer_ack_after",   32'(a), 32'd0);
    cyc(3'b111, 1'b1, 1'b0, 1'b0, v, d, a);
    chk("rst_first_grant_data", 32'(d), 32'd0);
    chk("rst_first_grant_ack",  32'(a), 32'b001);
    for (int p = 0; p < 3; p++) ack_tot[p] = 0;
    run(20, 3'b001, 1'b1);
    chk("rst_credits_restored", ack_tot[0], C - 1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc(3'($urandom_range(0, 7)),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 80) == 0),
          v, d, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/merge_arbiter.md
MERGE_ARBITER -- requirements
Module: merge_arbiter

Interface
REQ-001 Parameter: CREDITS, default 4, downstream flit slots available to the merge output; legal range 1..7.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  3  bit i high means input port i holds a flit for this output.
REQ-006 req_ack  out  3  one-hot, one-cycle pulse: the flit on port i has been scheduled and its req must drop at the next edge.
REQ-007 ctrl_valid  out  1  a select token is offered to the merge control channel.
REQ-008 ctrl_ready  in  1  the merge accepts the select token.
REQ-009 ctrl_data  out  2  select value, 0..2 only; 3 is never driven.
REQ-010 credit_ret  in  1  one-cycle pulse: downstream freed one slot.
REQ-011 credit_err  out  1  sticky flag: credit overflow detected.

Function
REQ-012 FSM states: IDLE and OFFER; no other states are reachable.
REQ-013 IDLE->OFFER when req!=0 and credit count >0; ctrl_data is then registered from the round-robin pick.
REQ-014 Otherwise IDLE stays in IDLE, and ctrl_valid=0.
REQ-015 OFFER drives ctrl_valid=1 and holds ctrl_data stable until ctrl_ready=1.
REQ-016 In OFFER, req is ignored and no re-pick occurs.
REQ-017 OFFER->IDLE on the cycle where ctrl_valid and ctrl_ready are both high.
REQ-018 In that same cycle, req_ack[ctrl_data] =1 (combinational), the credit count decrements, and last_grant <= ctrl_data.
REQ-019 After each accepted token there is exactly one IDLE bubble, so the peak rate is one token per 2 cycles and stale req is never granted.
REQ-020 Round-robin: search order is last_grant+1, last_grant+2, last_grant+3, taken mod 3; the first set req bit wins.
REQ-021 A granted port gets lowest priority on the next pick.
REQ-022 Credit counter width is 3 bits; it stays in 0..CREDITS.
REQ-023 Credit update: accept alone decrements; credit_ret alone increments; both in the same cycle leave the count unchanged.
REQ-024 credit_ret with count==CREDITS and no simultaneous accept: the count saturates at CREDITS and credit_err sets; credit_err clears only on reset.
REQ-025 Count==0: no transition to OFFER; a token already in OFFER still completes.
REQ-026 req_ack is zero in every cycle except the accept cycle.

Reset
REQ-027 Reset values: state=IDLE, ctrl_valid=0, ctrl_data=0, req_ack=0, credit count=CREDITS, last_grant=2 (port 0 has first priority), credit_err=0.
REQ-028 Reset asserted while in OFFER: the token is abandoned, and no req_ack pulses in that cycle or after.
REQ-029 Reset dominates every other input in the same cycle.

Structure
REQ-030 Shared package noc_pkg holds: NUM_IN=3, SEL_W=2, FLIT_W=11, and the arb_state_t enum {IDLE, OFFER}.
REQ-031 The round-robin pick is a separate combinational sub-module rr_pick3 with inputs req[2:0] and last[1:0], and outputs sel[1:0] and any.
REQ-032 The FSM, credit counter and error flag reside in merge_arbiter.

Verification
REQ-033 Reset, then req=3'b111 with ctrl_ready held 1: ctrl_data sequence is 0,1,2,0, and each req_ack bit pulses exactly once per token.
REQ-034 CREDITS=4, req=3'b001, no credit_ret: exactly 4 tokens are issued, then ctrl_valid stays 0. One credit_ret pulse then yields exactly one more token.
REQ-035 Enter OFFER with ctrl_data=1 and ctrl_ready=0 for 5 cycles while req changes to 3'b100: ctrl_data stays 1 and req_ack stays 0 until ctrl_ready rises.
REQ-036 Accept cycle coinciding with a credit_ret pulse at count 2: the count stays 2, with no spurious credit_err.
REQ-037 credit_ret at count=4 with no accept: the count stays 4 and credit_err=1 until reset.
REQ-038 Reset during OFFER: on the next cycle ctrl_valid=0, req_ack=0, count=CREDITS, and the first post-reset grant goes to port 0 when req=3'b111.
